// File: rtl/rst_sequencer.sv
// rst_sequencer: synchronises reset release, holds all domains, releases
// NUM_CH channels in staggered order, pulses boot PC load, then reports ready.
// Ports: clk, rst (async high), soft_rst_req, boot_addr -> rst_out[NUM_CH],
//        boot_pc_load, boot_pc[XLEN], ready, rst_cause[2].
module rst_sequencer #(
  parameter int NUM_CH      = 3,
  parameter int HOLD_CYCLES = 2,
  parameter int STAGGER     = 1,
  parameter int XLEN        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst_req,
  input  logic [XLEN-1:0]   boot_addr,
  output logic [NUM_CH-1:0] rst_out,
  output logic              boot_pc_load,
  output logic [XLEN-1:0]   boot_pc,
  output logic              ready,
  output logic [1:0]        rst_cause
);

  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MAXC = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int NW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] LAST  = CW'(NUM_CH - 1);
  localparam logic [CW-1:0] FIRST = CW'((NUM_CH > 1) ? 1 : 0);
  localparam logic [NW-1:0] HLAST = NW'(HOLD_CYCLES - 1);
  localparam logic [NW-1:0] SLAST = NW'(STAGGER - 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_HOLD,
    S_RELEASE,
    S_BOOT,
    S_RUN
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [1:0]    sync;
  logic [NW-1:0] cnt;
  logic [CW-1:0] ch;
  logic          soft_go;
  logic          hold_done;
  logic          all_clear;

  assign soft_go   = (state == S_RUN) && soft_rst_req;
  assign hold_done = (state == S_HOLD) && (cnt == HLAST);
  assign all_clear = ~rst_out[NUM_CH-1];

  // Set asynchronously, released by shifting zeros in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RESET;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_RESET:   if (!sync[1])  state_n = S_HOLD;
      S_HOLD:    if (hold_done) state_n = S_RELEASE;
      S_RELEASE: if (all_clear) state_n = S_BOOT;
      S_BOOT:    state_n = S_RUN;
      S_RUN:     if (soft_go)   state_n = S_HOLD;
      default:   state_n = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_out      <= '1;
      boot_pc_load <= 1'b0;
      boot_pc      <= '0;
      ready        <= 1'b0;
      rst_cause    <= 2'b01;
      cnt          <= '0;
      ch           <= '0;
    end else begin
      boot_pc_load <= (state_n == S_BOOT);
      ready        <= (state_n == S_RUN);
      unique case (state)
        S_RESET: cnt <= '0;
        S_HOLD: begin
          if (hold_done) begin
            rst_out[0] <= 1'b0;
            cnt        <= '0;
            ch         <= FIRST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (all_clear) begin
            boot_pc <= boot_addr;
          end else if (cnt == SLAST) begin
            rst_out[ch] <= 1'b0;
            cnt         <= '0;
            // Saturate so the index never walks past the last channel.
            if (ch != LAST) ch <= ch + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (soft_go) begin
            rst_out   <= '1;
            rst_cause <= 2'b10;
            cnt       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
